bicubic_round_scheduler: RTL
============================

// Module: bicubic_round_scheduler
// PURPOSE
// - Shares one bicubic_nx_round SIMD rounding resource among NUM_REQ pipeline requesters.
// - Round-robin arbitration with a valid/ready request side and a tagged, latency-matched response side.
// - Also sequences the rounding unit's clock enable and DSP synchronous reset, including a flush/drain mode.
// - Sits between the bicubic MAC stages and the shared rounding instance.
// PARAMETERS
// - NUM_REQ        4   number of requesters (2..8)
// - PARALLEL_CORE  2   SIMD cores in the rounding unit
// - INPUT_WIDTH    48  per-core input width
// - OUTPUT_WIDTH   9   per-core output width
// - ROUND_LATENCY  3   rout cycles after rin, counted in clken-high cycles (>=1)
// PORTS
// - clk            in   1                       clock
// - reset          in   1                       synchronous, active-high
// - req_valid      in   NUM_REQ                 per-requester request valid
// - req_ready      out  NUM_REQ                 one-hot grant; transfer = valid&ready
// - req_ch0        in   NUM_REQ*IW*PC           packed ch0 data, requester i at slice i
// - req_ch1        in   NUM_REQ*IW*PC           packed ch1 data
// - rsp_valid      out  NUM_REQ                 one-hot result strobe, no backpressure
// - rsp_ch0        out  OW*PC                   shared result bus ch0 (=rout_ch0)
// - rsp_ch1        out  OW*PC                   shared result bus ch1
// - flush_req      in   1                       stop granting and drain in-flight work
// - flush_done     out  1                       1-cycle pulse when drain completes
// - round_clken    out  1                       to rounding unit clken
// - round_dsp_reset out 1                       to rounding unit dsp_reset
// - round_rin_ch0  out  IW*PC                   registered operand ch0
// - round_rin_ch1  out  IW*PC                   registered operand ch1
// - round_rout_ch0 in   OW*PC                   rounding result ch0
// - round_rout_ch1 in   OW*PC                   rounding result ch1
// - stat_grant_cnt out  NUM_REQ*32              per-requester grant counters (optional feature)
// BEHAVIOUR
// - Reset: state=HOLD, req_ready=0, rsp_valid=0, flush_done=0, round_rin=0, tag pipe cleared, rr_ptr=0.
// - Reset: round_dsp_reset=1, round_clken=1.
// - FSM states: HOLD, RUN, DRAIN, IDLE.
//   - HOLD: round_dsp_reset=1 for ROUND_LATENCY cycles after reset falls, no grants; then -> RUN.
//   - RUN: arbitrate every cycle. flush_req=1 -> DRAIN (no grant in that cycle).
//   - DRAIN: no grants; when in-flight count==0 -> pulse flush_done, go to IDLE.
//   - IDLE: no grants, round_clken=0. flush_req=0 -> RUN next cycle.
// - Arbitration: grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - req_ready is combinational from req_valid; at most one bit is set.
//   - On a grant, rr_ptr <= g+1 mod NUM_REQ. Without a grant, rr_ptr holds.
// - Issue: on a grant, round_rin_ch0/ch1 <= the granted slice at the next edge.
//   - The tag pipe (valid + index, depth ROUND_LATENCY+1) shifts in {1,g}, otherwise a bubble {0,x}.
// - round_clken=1 in HOLD/RUN/DRAIN; 0 only in IDLE (in-flight is always 0 there). Tag pipe advances only when round_clken=1.
// - Latency: request accepted at edge T -> rsp_valid[g]=1 in cycle T+1+ROUND_LATENCY.
//   - rsp_ch0/ch1 = round_rout passthrough; rsp_valid one-hot from the tag pipe output.
//   - Sustained throughput: 1 result/cycle; responses keep grant order.
// - In-flight counter: counts valid tags in the pipe (0..ROUND_LATENCY+1).
//   - Issue and retire in the same cycle -> unchanged.
// - Simultaneous flush_req and a pending request in RUN: the flush wins, no grant.
// - reset mid-operation: in-flight results are discarded (no rsp_valid); the full HOLD sequence is re-run.
// - Widths: pure routing, no arithmetic on data. Counters saturate at 2^32-1.
// CONFIGURATION
// - BICUBIC_ROUND_SCHED_STATS_EN defined:
//   - stat_grant_cnt[i] increments on each grant to requester i.
//   - Counters are cleared by reset and saturate.
// - BICUBIC_ROUND_SCHED_STATS_EN undefined: stat_grant_cnt is tied to 0 and no counter logic exists.
// TESTING
// - Reset, then idle: round_dsp_reset high for 3 cycles after reset falls, req_ready=0 during HOLD; RUN entered on cycle 4.
// - req_valid=4'b1111 held, rr_ptr=0: grants 0,1,2,3,0... one per cycle; rsp_valid[i] appears 4 cycles after its grant with matching data.
// - req_valid=4'b0101 only: grants alternate 0,2,0,2; rr_ptr skips idle requesters; no rsp_valid on requesters 1 and 3.
// - Issue 3 requests, then flush_req=1: no new grants; flush_done pulses the cycle after the last rsp_valid; round_clken=0 in IDLE.
// - Assert reset with 2 results in flight: no rsp_valid for them; HOLD re-run; a fresh request completes with correct data.
// - STATS_EN build, 10 grants to requester 1: stat_grant_cnt[1]=10, others 0. Non-STATS build: all 0.

Source files
------------

// File: rtl/bicubic_round_scheduler.sv
// Round-robin scheduler sharing one bicubic_nx_round SIMD rounding unit among NUM_REQ requesters.
// Optional per-requester grant counters are built when BICUBIC_ROUND_SCHED_STATS_EN is defined.
module bicubic_round_scheduler #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned PARALLEL_CORE = 2,
  parameter int unsigned INPUT_WIDTH   = 48,
  parameter int unsigned OUTPUT_WIDTH  = 9,
  parameter int unsigned ROUND_LATENCY = 3
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQ-1:0]                            req_valid,
  output logic [NUM_REQ-1:0]                            req_ready,
  input  logic [NUM_REQ*INPUT_WIDTH*PARALLEL_CORE-1:0]  req_ch0,
  input  logic [NUM_REQ*INPUT_WIDTH*PARALLEL_CORE-1:0]  req_ch1,
  output logic [NUM_REQ-1:0]                            rsp_valid,
  output logic [OUTPUT_WIDTH*PARALLEL_CORE-1:0]         rsp_ch0,
  output logic [OUTPUT_WIDTH*PARALLEL_CORE-1:0]         rsp_ch1,
  input  logic                                          flush_req,
  output logic                                          flush_done,
  output logic                                          round_clken,
  output logic                                          round_dsp_reset,
  output logic [INPUT_WIDTH*PARALLEL_CORE-1:0]          round_rin_ch0,
  output logic [INPUT_WIDTH*PARALLEL_CORE-1:0]          round_rin_ch1,
  input  logic [OUTPUT_WIDTH*PARALLEL_CORE-1:0]         round_rout_ch0,
  input  logic [OUTPUT_WIDTH*PARALLEL_CORE-1:0]         round_rout_ch1,
  output logic [NUM_REQ*32-1:0]                         stat_grant_cnt
);

  localparam int unsigned DW     = INPUT_WIDTH * PARALLEL_CORE;
  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned DEPTH  = ROUND_LATENCY + 1;
  localparam int unsigned CNT_W  = $clog2(ROUND_LATENCY + 2);
  localparam int unsigned HOLD_W = $clog2(ROUND_LATENCY + 1);

  typedef enum logic [1:0] {HOLD, RUN, DRAIN, IDLE} state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              flush_done_q, flush_done_d;
  logic [DW-1:0]     rin0_q, rin1_q;
  tag_t              tag_q [DEPTH];

  logic              arb_en_c;
  logic              gnt_vld_c;
  logic [IDX_W-1:0]  gnt_idx_c;
  logic [IDX_W-1:0]  cand_c;
  logic [NUM_REQ-1:0] grant_c;
  logic              retire_c;

  assign arb_en_c        = (state_q == RUN) && !flush_req;
  assign round_clken     = (state_q != IDLE);
  assign round_dsp_reset = (state_q == HOLD);
  assign flush_done      = flush_done_q;
  assign round_rin_ch0   = rin0_q;
  assign round_rin_ch1   = rin1_q;
  assign rsp_ch0         = round_rout_ch0;
  assign rsp_ch1         = round_rout_ch1;
  assign req_ready       = grant_c;
  assign retire_c        = tag_q[DEPTH-1].vld && round_clken;

  // Round-robin search starting at rr_ptr; first valid requester wins
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    cand_c    = '0;
    grant_c   = '0;
    if (arb_en_c) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        cand_c = IDX_W'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
        if (!gnt_vld_c && req_valid[cand_c]) begin
          gnt_vld_c = 1'b1;
          gnt_idx_c = cand_c;
        end
      end
    end
    if (gnt_vld_c) grant_c[gnt_idx_c] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld_c) begin
      rr_ptr_d = (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
    end
    inflight_d = inflight_q + CNT_W'(gnt_vld_c) - CNT_W'(retire_c);
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_q[DEPTH-1].vld) rsp_valid[tag_q[DEPTH-1].idx] = 1'b1;
  end

  // Next-state logic; DRAIN completes once the pipe is empty after this cycle's retire
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    flush_done_d = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (hold_cnt_q == HOLD_W'(ROUND_LATENCY - 1)) state_d = RUN;
        else hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      RUN: begin
        if (flush_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (inflight_d == '0) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (!flush_req) state_d = RUN;
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HOLD;
      hold_cnt_q   <= '0;
      rr_ptr_q     <= '0;
      inflight_q   <= '0;
      flush_done_q <= 1'b0;
      rin0_q       <= '0;
      rin1_q       <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      inflight_q   <= inflight_d;
      flush_done_q <= flush_done_d;
      if (gnt_vld_c) begin
        rin0_q <= req_ch0[gnt_idx_c*DW +: DW];
        rin1_q <= req_ch1[gnt_idx_c*DW +: DW];
      end
    end
  end

  // Tag pipe mirrors the rounding unit latency plus the operand register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(DEPTH); k++) tag_q[k] <= '0;
    end else if (round_clken) begin
      tag_q[0] <= '{vld: gnt_vld_c, idx: gnt_idx_c};
      for (int k = 1; k < int'(DEPTH); k++) tag_q[k] <= tag_q[k-1];
    end
  end

`ifdef BICUBIC_ROUND_SCHED_STATS_EN
  logic [31:0] stat_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REQ); i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (grant_c[i] && (stat_q[i] != 32'hFFFF_FFFF)) stat_q[i] <= stat_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) stat_grant_cnt[i*32 +: 32] = stat_q[i];
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule
